pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle fetch/execute sequencer that owns the word-addressed program counter and drives next-address selection for the MIPS core. It issues instruction-memory requests, hands each fetched instruction to decode, waits for execute to resolve it, then applies jump/branch/sequential next-address rules. It sits between instruction memory and the decode/execute stages and replaces free-running PC update with an explicit handshake-driven schedule.

## Interface
- RESET_VECTOR, 30'h0000_0C00: word address loaded into PC on reset (byte 0x0000_3000).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  [31:2]  word address of fetch; equals pc.
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction.
- inst_valid  out  1  inst/inst_pc valid for decode.
- inst  out  32  registered instruction.
- inst_pc  out  [31:2]  address of inst.
- inst_ready  in  1  decode accepts inst.
- exec_done  in  1  execute has resolved the issued instruction (one-cycle pulse).
- jump  in  1  resolved instruction is a jump (sampled with exec_done).
- branch  in  1  resolved instruction is a branch.
- zero  in  1  ALU zero flag for branch.
- extend_imme  in  [31:2]  sign-extended branch offset, in words.
- halt  in  1  stop after the current instruction (sampled with exec_done).
- halted  out  1  sequencer in HALT.
- instret  out  32  retired-instruction counter.

## Operation
- States: FETCH, ISSUE, EXEC, HALT.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: inst<=imem_rdata, inst_pc<=pc, go ISSUE. Ack may arrive in the first request cycle; req held high until ack.
- ISSUE: inst_valid=1; inst held stable. On inst_ready: go EXEC.
- EXEC: wait for exec_done. On exec_done: pc<=next address, instret<=instret+1; go HALT if halt, else FETCH.
- HALT: all handshake outputs low, halted=1; exits only via reset.
- Next address, priority order: jump -> {pc[31:28], inst[25:0]}; branch&&zero -> pc+1+extend_imme; else pc+1. Jump uses the registered inst, not imem_rdata.
- Arithmetic mod 2^30 on word address; pc+1 at 30'h3FFF_FFFF wraps to 0; negative extend_imme wraps naturally.
- instret wraps 32'hFFFF_FFFF -> 0.
- jump && branch && zero: jump wins.
- imem_ack outside FETCH, inst_ready outside ISSUE, exec_done outside EXEC: ignored, no state change.
- halt without exec_done: ignored.

## Timing
- Reset (async assert): state=FETCH, pc=RESET_VECTOR, inst=0, inst_pc=0, instret=0; imem_req deasserts immediately (combinational from state); inst_valid=0, halted=0.
- First imem_req=1 in the first cycle after rst_n deasserts.
- Minimum 3 cycles per instruction (ack, ready, done each in first cycle of their state); each stall cycle adds one.
- inst_valid asserts the cycle after the accepting ack; new pc visible on imem_addr the cycle after exec_done.
- Reset mid-fetch or mid-exec: instruction discarded, instret not incremented, restart from RESET_VECTOR.
- imem_req, inst_valid, halted decoded from registered state only; no combinational path from any input to any output.

## Structure
- Shared package mips_pkg: state enum (seq_state_t), default RESET_VECTOR constant, opcode field positions (J-index [25:0]).
- Sub-module next_addr_calc: purely combinational, inputs pc, inst[25:0], jump, branch, zero, extend_imme; output next pc. Reused by any later pipelined variant.
- FSM, pc, inst, inst_pc, instret registers in pc_sequencer.

## Test plan
- Reset then sequential: ack/ready/done immediately, no jump/branch, 4 instructions -> imem_addr 0xC00, 0xC01, 0xC02, 0xC03; instret=4; 3 cycles each.
- Branch taken/not taken: pc=0xC05, branch=1, extend_imme=30'h3FFF_FFFD (-3): zero=1 -> 0xC03; zero=0 -> 0xC06.
- Jump priority: pc=0xC00, inst[25:0]=26'h000_0100, jump=branch=zero=1 -> next 30'h0000_0100 (pc[31:28] kept).
- Wait states: imem_ack delayed 3 cycles, inst_ready 2 cycles -> imem_req held 4 cycles, inst stable while inst_valid; spurious exec_done during ISSUE ignored.
- Wrap and halt: pc=30'h3FFF_FFFF sequential -> 0; next exec_done with halt=1 -> halted=1, imem_req stays 0 for 20 cycles.
- Async reset asserted mid-EXEC -> outputs reset within the same cycle, restart at 0xC00, instret=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants.
// Sequencer state encoding, reset vector and J-format field layout.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    EXEC,
    HALT
  } seq_state_t;

  // Word address 0xC00 is byte address 0x0000_3000.
  localparam logic [31:2] RESET_VECTOR_DEFAULT = 30'h0000_0C00;

  localparam int J_IDX_LSB = 0;
  localparam int J_IDX_MSB = 25;
  localparam int J_IDX_W   = J_IDX_MSB - J_IDX_LSB + 1;

endpackage

// File: rtl/next_addr_calc.sv
// Next word address: jump, then taken branch, then sequential.
// Purely combinational; all arithmetic wraps mod 2^30.
module next_addr_calc
  import mips_pkg::*;
(
  input  logic [31:2]        pc,
  input  logic [J_IDX_W-1:0] j_idx,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  input  logic [31:2]        extend_imme,
  output logic [31:2]        next_pc
);

  logic [31:2] seq_pc;

  assign seq_pc = pc + 30'd1;

  // jump and taken branch may both be set, so this is a priority chain
  always_comb begin
    next_pc = seq_pc;
    if (jump)
      next_pc = {pc[31:28], j_idx};
    else if (branch && zero)
      next_pc = seq_pc + extend_imme;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/issue/execute sequencer owning the word PC.
// Handshake outputs decode from registered state only.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:2] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:2] inst_pc,
  input  logic        inst_ready,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:2] extend_imme,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] instret
);

  seq_state_t  state;
  logic [31:2] pc;
  logic [31:2] next_pc;
  // Low while reset is held so imem_req drops with the reset edge
  logic        live;

  next_addr_calc u_next (
    .pc          (pc),
    .j_idx       (inst[J_IDX_MSB:J_IDX_LSB]),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .extend_imme (extend_imme),
    .next_pc     (next_pc)
  );

  assign imem_addr  = pc;
  assign imem_req   = live && (state == FETCH);
  assign inst_valid = (state == ISSUE);
  assign halted     = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_VECTOR;
      inst    <= '0;
      inst_pc <= '0;
      instret <= '0;
      live    <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        FETCH: begin
          if (live && imem_ack) begin
            inst    <= imem_rdata;
            inst_pc <= pc;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (inst_ready)
            state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            pc      <= next_pc;
            instret <= instret + 32'd1;
            state   <= halt ? HALT : FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of instructions with a queue of
// expected fetch addresses, plus hand-written reset/halt sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:2] inst_pc;
  logic        inst_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:2] extend_imme = '0;
  logic        halt = 1'b0;
  logic        halted;
  logic [31:0] instret;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .exec_done   (exec_done),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .extend_imme (extend_imme),
    .halt        (halt),
    .halted      (halted),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        jump;
    logic        branch;
    logic        zero;
    logic        halt;
    logic        spur;
    logic [31:2] ext;
    int          ack_dly;
    int          rdy_dly;
    logic [31:2] addr;
  } vec_t;

  vec_t        tab[12];
  logic [31:2] sbq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          retired = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_ack    = 1'b0;
    inst_ready  = 1'b0;
    exec_done   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    halt        = 1'b0;
    extend_imme = '0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:2] exp_addr;
    int cyc;
    exp_addr = '0;
    cyc = 0;
    sbq.push_back(v.addr);
    for (int k = 0; k <= v.ack_dly; k++) begin
      chk("imem_req_fetch", {31'd0, imem_req}, 32'd1);
      chk("inst_valid_fetch", {31'd0, inst_valid}, 32'd0);
      if (k == v.ack_dly) begin
        if (sbq.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          exp_addr = sbq.pop_front();
          chk("imem_addr", {2'b00, imem_addr}, {2'b00, exp_addr});
        end
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        inst_ready = v.spur;
        exec_done  = v.spur;
      end
      @(negedge clk);
      cyc++;
    end
    clear_inputs();
    for (int k = 0; k <= v.rdy_dly; k++) begin
      chk("inst_valid_issue", {31'd0, inst_valid}, 32'd1);
      chk("imem_req_issue", {31'd0, imem_req}, 32'd0);
      chk("inst", inst, v.rdata);
      chk("inst_pc", {2'b00, inst_pc}, {2'b00, exp_addr});
      inst_ready = (k == v.rdy_dly);
      if (v.spur && k < v.rdy_dly) begin
        exec_done  = 1'b1;
        halt       = 1'b1;
        jump       = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = ~v.rdata;
      end
      @(negedge clk);
      cyc++;
      clear_inputs();
    end
    chk("inst_valid_exec", {31'd0, inst_valid}, 32'd0);
    chk("imem_req_exec", {31'd0, imem_req}, 32'd0);
    exec_done   = 1'b1;
    jump        = v.jump;
    branch      = v.branch;
    zero        = v.zero;
    extend_imme = v.ext;
    halt        = v.halt;
    @(negedge clk);
    cyc++;
    clear_inputs();
    retired++;
    chk("cycles", 32'(cyc), 32'(3 + v.ack_dly + v.rdy_dly));
    chk("instret", instret, 32'(retired));
    chk("halted", {31'd0, halted}, {31'd0, v.halt});
  endtask

  task automatic set_vec(input int i, input logic [31:0] rdata,
                         input logic j, input logic b, input logic z,
                         input logic h, input logic s,
                         input logic [31:2] ext, input int ad,
                         input int rd, input logic [31:2] addr);
    tab[i].rdata   = rdata;
    tab[i].jump    = j;
    tab[i].branch  = b;
    tab[i].zero    = z;
    tab[i].halt    = h;
    tab[i].spur    = s;
    tab[i].ext     = ext;
    tab[i].ack_dly = ad;
    tab[i].rdy_dly = rd;
    tab[i].addr    = addr;
  endtask

  initial begin
    //       rdata         j  b  z  h  s  ext            ack rdy addr
    set_vec(0, 32'h2000_0001, 0, 0, 0, 0, 0, 30'h0,          0, 0, 30'h0C00);
    set_vec(1, 32'h2000_0002, 0, 0, 0, 0, 0, 30'h0,          0, 0, 30'h0C01);
    set_vec(2, 32'h2000_0003, 0, 0, 0, 0, 0, 30'h0,          0, 0, 30'h0C02);
    set_vec(3, 32'h2000_0004, 0, 0, 0, 0, 0, 30'h0,          0, 0, 30'h0C03);
    set_vec(4, 32'h8C00_0010, 0, 0, 0, 0, 0, 30'h0,          0, 0, 30'h0C04);
    set_vec(5, 32'h1000_FFFD, 0, 1, 1, 0, 0, 30'h3FFF_FFFD,  0, 0, 30'h0C05);
    set_vec(6, 32'h0800_0C05, 1, 0, 0, 0, 0, 30'h0,          0, 0, 30'h0C03);
    set_vec(7, 32'h1000_FFFD, 0, 1, 0, 0, 0, 30'h3FFF_FFFD,  0, 0, 30'h0C05);
    set_vec(8, 32'h0800_0100, 1, 1, 1, 0, 0, 30'h3FFF_FFFD,  0, 0, 30'h0C06);
    set_vec(9, 32'h1000_0000, 0, 1, 1, 0, 1, 30'h3FFF_FEFE,  3, 2, 30'h0100);
    set_vec(10, 32'h0000_0020, 0, 0, 0, 0, 0, 30'h0,         0, 0, 30'h3FFF_FFFF);
    set_vec(11, 32'h0000_000D, 0, 0, 0, 1, 0, 30'h0,         1, 1, 30'h0000_0000);

    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_imem_addr", {2'b00, imem_addr}, 32'h0000_0C00);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", {2'b00, inst_pc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(tab[i]);

    chk("halt_pc", {2'b00, imem_addr}, 32'h0000_0001);
    for (int k = 0; k < 20; k++) begin
      imem_ack   = 1'($urandom);
      inst_ready = 1'($urandom);
      exec_done  = 1'($urandom);
      @(negedge clk);
      chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
      chk("halt_halted", {31'd0, halted}, 32'd1);
    end
    clear_inputs();
    chk("halt_instret", instret, 32'd12);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    retired = 0;
    @(negedge clk);
    chk("restart_halted", {31'd0, halted}, 32'd0);
    set_vec(0, 32'h2000_0001, 0, 0, 0, 0, 0, 30'h0, 0, 0, 30'h0C00);
    run_vec(tab[0]);

    imem_ack   = 1'b1;
    imem_rdata = 32'h0800_0123;
    @(negedge clk);
    clear_inputs();
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("midexec_inst", inst, 32'h0800_0123);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_instret", instret, 32'd0);
    chk("arst_imem_addr", {2'b00, imem_addr}, 32'h0000_0C00);
    chk("arst_inst", inst, 32'd0);
    exec_done = 1'b1;
    jump      = 1'b1;
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    retired = 0;
    @(negedge clk);
    run_vec(tab[0]);
    chk("restart_pc", {2'b00, imem_addr}, 32'h0000_0C01);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
